gcd_lcm_unit: RTL and testbench

//  Multi-cycle GCD/LCM coprocessor fed by the single-cycle RISC-V datapath (rs1/rs2 values).

---
 rtl/gcd_lcm_pkg.sv | 12 +
 rtl/gcd_lcm_divu.sv | 57 +++++
 rtl/gcd_lcm_unit.sv | 161 ++++++++++++++++
 tb/tb_gcd_lcm_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gcd_lcm_pkg.sv
// Shared types for the GCD/LCM coprocessor: FSM states, operation codes and a
// width helper for the Stein common-shift counter.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, GCD_RUN, DIV, MUL, DONE} state_t;
  typedef enum logic {OP_GCD = 1'b0, OP_LCM = 1'b1} op_t;

  function automatic int unsigned k_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_lcm_divu.sv
// Fixed-latency restoring divider: quotient valid with a done pulse exactly
// WIDTH cycles after start.
module gcd_lcm_divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;

  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   rdiff;
  logic             fits;

  // Partial remainder stays below 2*divisor, so one extra bit is enough.
  assign rsh   = {rem_q, quo_q[WIDTH-1]};
  assign fits  = (rsh >= {1'b0, dvs_q});
  assign rdiff = rsh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= fits ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], fits};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD/LCM coprocessor (Stein GCD, divide, shift-add multiply).
// Build option GCDLCM_OVF_SAT_EN: saturate the LCM result to all-ones on overflow.
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int KW = k_width(WIDTH);

  state_t             state_q;
  op_t                op_q;
  logic [WIDTH-1:0]   src_a_q, src_b_q, a_q, b_q, g_q, mpl_q, result_q;
  logic [KW-1:0]      k_q, cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic               busy_q, done_q, ovf_q, div_start_q;

  logic [WIDTH-1:0]   a_d, b_d, g, lcm_res, div_quo;
  logic [KW-1:0]      k_d;
  logic [2*WIDTH-1:0] acc_d;
  logic               div_done, lcm_ovf;

  // The difference of two odd values is always even, so its halving is folded
  // into the subtract step; this keeps the worst case inside 2*WIDTH+4 cycles.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    if (!a_q[0] && !b_q[0]) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      k_d = k_q + 1'b1;
    end else if (!a_q[0]) begin
      a_d = a_q >> 1;
    end else if (!b_q[0]) begin
      b_d = b_q >> 1;
    end else if (a_q > b_q) begin
      a_d = (a_q - b_q) >> 1;
    end else begin
      b_d = (b_q - a_q) >> 1;
    end
  end

  assign g       = a_q << k_q;
  assign acc_d   = acc_q + (mpl_q[0] ? mcand_q : '0);
  assign lcm_ovf = |acc_d[2*WIDTH-1:WIDTH];

`ifdef GCDLCM_OVF_SAT_EN
  assign lcm_res = lcm_ovf ? {WIDTH{1'b1}} : acc_d[WIDTH-1:0];
`else
  assign lcm_res = acc_d[WIDTH-1:0];
`endif

  gcd_lcm_divu #(.WIDTH(WIDTH)) u_divu (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_q),
    .dividend (src_a_q),
    .divisor  (g_q),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_t'(op);
            src_a_q <= src_a;
            src_b_q <= src_b;
            a_q     <= src_a;
            b_q     <= src_b;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (a_q == '0 || b_q == '0) begin
            result_q <= (op_q == OP_GCD) ? (a_q | b_q) : '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q <= GCD_RUN;
          end
        end
        GCD_RUN: begin
          if (a_q == b_q) begin
            if (op_q == OP_GCD) begin
              result_q <= g;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              g_q         <= g;
              div_start_q <= 1'b1;
              state_q     <= DIV;
            end
          end else begin
            a_q <= a_d;
            b_q <= b_d;
            k_q <= k_d;
          end
        end
        DIV: begin
          if (div_done) begin
            mcand_q <= {{WIDTH{1'b0}}, div_quo};
            mpl_q   <= src_b_q;
            acc_q   <= '0;
            cnt_q   <= KW'(WIDTH);
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mpl_q   <= mpl_q >> 1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == KW'(1)) begin
            result_q <= lcm_res;
            ovf_q    <= lcm_ovf;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed cases plus random operands
// checked against an arithmetic GCD/LCM reference model.
module tb_gcd_lcm_unit;

  localparam int W = 32;

`ifdef GCDLCM_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] src_a, src_b, result;
  logic         busy, done, ovf;

  int checks   = 0;
  int failures = 0;
  int lat;
  int dones;

  gcd_lcm_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic v);
    longint unsigned g, p;
    g = ref_gcd(a, b);
    if (o == 1'b0) begin
      r = g[W-1:0];
      v = 1'b0;
    end else if (a == 0 || b == 0) begin
      r = '0;
      v = 1'b0;
    end else begin
      p = (longint'(a) / g) * longint'(b);
      v = (p >> W) != 0;
      r = (v && SAT) ? {W{1'b1}} : p[W-1:0];
    end
  endtask

  // Issue one operation from an idle cycle; optionally pulse a second start at
  // cycle 5 of the run. Waits for done with a cycle budget, then one more cycle.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int budget, input bit inject);
    logic [W-1:0] er;
    logic         ev;
    ref_op(o, a, b, er, ev);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    dones = 0;
    chk({tag, ".busy1"}, busy, 1'b1);
    while (!done && lat < budget) begin
      if (inject && lat == 5) begin
        start = 1'b1; op = 1'b0; src_a = 9; src_b = 3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".ovf"}, ovf, ev);
    chk({tag, ".busy_at_done"}, busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         ro;
    reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.result", result, '0);
    chk("rst.ovf", ovf, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("gcd48_18", 1'b0, 48, 18, 2*W+4, 1'b0);
    chk("gcd48_18.lat_bound", lat <= 2*W+4, 1'b1);
    run_op("lcm4_6", 1'b1, 4, 6, 300, 1'b0);
    run_op("lcm21_6", 1'b1, 21, 6, 300, 1'b0);

    run_op("gcd0_7", 1'b0, 0, 7, 10, 1'b0);
    chk("gcd0_7.lat", lat, 2);
    run_op("gcd0_0", 1'b0, 0, 0, 10, 1'b0);
    chk("gcd0_0.lat", lat, 2);
    run_op("lcm0_7", 1'b1, 0, 7, 10, 1'b0);
    chk("lcm0_7.lat", lat, 2);

    run_op("lcm_ovf", 1'b1, 32'h0001_0000, 32'h0001_0001, 300, 1'b0);
    chk("lcm_ovf.result_const", result, SAT ? 32'hFFFF_FFFF : 32'h0001_0000);

    // Second start mid-LCM must be dropped: no extra done, no new busy period.
    run_op("ignore2nd", 1'b1, 21, 6, 300, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("ignore2nd.extra_done", dones, 0);
    chk("ignore2nd.busy_after", busy, 1'b0);

    // Reset while the divider is running.
    start = 1'b1; op = 1'b1; src_a = 21; src_b = 6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.result", result, '0);
    chk("midrst.done", done, 1'b0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("midrst.no_done", dones, 0);
    run_op("gcd35_14", 1'b0, 35, 14, 2*W+4, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) rb = ra * $urandom_range(1, 5);
      ro = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", n), ro, ra, rb, ro ? 4*W+16 : 2*W+4, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
